// File: rtl/ahb_resp_mux_ds_if.sv
// ahb_resp_mux_ds_if: slave-side inputs and master-side outputs of the AHB response mux
interface ahb_resp_mux_ds_if #(
    parameter int NUM_SLAVES  = 4,
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32
);
    localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    logic [NUM_SLAVES-1:0]                  slave_select;
    logic [1:0]                             Htrans;
    logic [MW-1:0]                          Hmaster;
    logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  Hrdata_S;
    logic [NUM_SLAVES-1:0][1:0]             Hresp_S;
    logic [NUM_SLAVES-1:0]                  Hreadyout_S;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] Hrdata;
    logic [NUM_MASTERS-1:0][1:0]            Hresp;
    logic                                   Hready;
    logic                                   timeout_err;
    modport slave (
        input  slave_select, Htrans, Hmaster, Hrdata_S, Hresp_S, Hreadyout_S,
        output Hrdata, Hresp, Hready, timeout_err
    );
    modport master (
        output slave_select, Htrans, Hmaster, Hrdata_S, Hresp_S, Hreadyout_S,
        input  Hrdata, Hresp, Hready, timeout_err
    );
endinterface

// File: rtl/ahb_resp_mux_ds.sv
// ahb_resp_mux_ds: data-phase response mux with default slave and wait-state watchdog
module ahb_resp_mux_ds #(
    parameter int          NUM_SLAVES     = 4,
    parameter int          NUM_MASTERS    = 2,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] DEFAULT_RDATA  = 32'hDEADBEEF
) (
    input logic              Hclk,
    input logic              Hresetn,
    ahb_resp_mux_ds_if.slave bus
);
    localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   dp_sel_q, dp_sel_d;
    logic [MW-1:0]           dp_master_q, dp_master_d;
    logic                    tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [1:0]              sel_resp;
    logic                    sel_ready, hready, wd_fire, unused_ok;
    assign unused_ok = bus.Htrans[0];
    always_comb begin
        sel_rdata = '0;
        sel_resp  = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            sel_rdata |= dp_sel_q[s] ? bus.Hrdata_S[s] : '0;
            sel_resp  |= dp_sel_q[s] ? bus.Hresp_S[s] : '0;
        end
    end
    assign sel_ready = |(dp_sel_q & bus.Hreadyout_S);
    assign hready    = state_q == DATA ? sel_ready : state_q != ERR1;
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            logic [CW-1:0] cnt_q, cnt_d;
            // any accepted cycle restarts the count, so entry to DATA always starts at zero
            always_comb cnt_d = hready ? '0 : state_q == DATA ? cnt_q + CW'(1) : cnt_q;
            always_ff @(posedge Hclk or negedge Hresetn) begin
                if (!Hresetn) cnt_q <= '0;
                else          cnt_q <= cnt_d;
            end
            assign wd_fire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
        end else begin : g_nowd
            assign wd_fire = 1'b0;
        end
    endgenerate
    always_comb begin
        state_d     = state_q;
        dp_sel_d    = dp_sel_q;
        dp_master_d = dp_master_q;
        tmo_d       = 1'b0;
        if (state_q == ERR1) begin
            state_d = ERR2;
        end else if (state_q == DATA && !sel_ready && wd_fire) begin
            state_d = ERR1;
            tmo_d   = 1'b1;
        end else if (hready) begin
            dp_master_d = bus.Hmaster;
            dp_sel_d    = bus.Htrans[1] && $onehot(bus.slave_select) ? bus.slave_select : '0;
            state_d     = !bus.Htrans[1] ? IDLE : $onehot(bus.slave_select) ? DATA : ERR1;
        end
    end
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= IDLE;
            dp_sel_q    <= '0;
            dp_master_q <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dp_sel_q    <= dp_sel_d;
            dp_master_q <= dp_master_d;
            tmo_q       <= tmo_d;
        end
    end
    always_comb begin
        bus.Hrdata = '0;
        bus.Hresp  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (dp_master_q == MW'(m)) begin
                bus.Hrdata[m] = state_q == DATA ? sel_rdata : state_q == IDLE ? '0 : DATA_WIDTH'(DEFAULT_RDATA);
                bus.Hresp[m]  = state_q == DATA ? sel_resp : state_q == IDLE ? 2'b00 : 2'b01;
            end
        end
    end
    assign bus.Hready      = hready;
    assign bus.timeout_err = tmo_q;
endmodule

// File: doc/ahb_resp_mux_ds.md
Name: ahb_resp_mux_ds

Overview:
Parametrised slave-to-master response multiplexer with an integrated default slave and a wait-state watchdog.
- Registers the address-phase slave select and owning master, so the data phase is steered correctly.
- Routes the selected slave's read data and response only to the master that owns the data phase.
- Generates the AHB two-cycle ERROR response for unmapped transfers and for slaves that stall past a timeout.
- Sits between the slave ports and the master ports of the interconnect, alongside the decoder and arbiter.

Parameters:
NUM_SLAVES, 4, number of slave ports (>=1)
NUM_MASTERS, 2, number of master ports (>=1)
DATA_WIDTH, 32, read data width
TIMEOUT_CYCLES, 16, consecutive wait cycles before the watchdog error; 0 disables the watchdog
DEFAULT_RDATA, 32'hDEADBEEF, read data driven during default/error responses (truncated/zero-extended to DATA_WIDTH)

Ports:
Hclk  in  1  bus clock; one clock domain, all state on its rising edge
Hresetn  in  1  asynchronous active-low reset
slave_select  in  NUM_SLAVES  one-hot address-phase select from decoder
Htrans  in  2  address-phase transfer type of the granted master
Hmaster  in  MW=max(1,$clog2(NUM_MASTERS))  address-phase owning master index
Hrdata_S  in  DATA_WIDTH x NUM_SLAVES  slave read data
Hresp_S  in  2 x NUM_SLAVES  slave responses (00 OKAY, 01 ERROR)
Hreadyout_S  in  1 x NUM_SLAVES  slave ready outputs
Hrdata  out  DATA_WIDTH x NUM_MASTERS  per-master read data
Hresp  out  2 x NUM_MASTERS  per-master response
Hready  out  1  global HREADY, fed back to all slaves and masters
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (asynchronous, any time, including mid-burst or mid-error):
  - state=IDLE, dp_sel=0, dp_master=0, wait counter=0.
  - Outputs: Hready=1, all Hresp=00, all Hrdata=0, timeout_err=0.
- Address latch: occurs only in a cycle with Hready=1.
  - dp_master <= Hmaster.
  - If Htrans[1]=1 (NONSEQ/SEQ) and slave_select has exactly one bit set: dp_sel <= slave_select, next state DATA.
  - If Htrans[1]=1 and slave_select is zero or has more than one bit set: next state ERR1.
  - If Htrans[1]=0 (IDLE/BUSY): dp_sel <= 0, next state IDLE.
- IDLE: Hready=1; all Hresp=00; all Hrdata=0.
- DATA:
  - Hrdata[dp_master]=Hrdata_S[k], Hresp[dp_master]=Hresp_S[k], Hready=Hreadyout_S[k], where k is the set bit of dp_sel.
  - Slave ERROR responses pass through unchanged.
- ERR1: Hready=0; Hresp[dp_master]=01; Hrdata[dp_master]=DEFAULT_RDATA. Next state is always ERR2.
- ERR2: same as ERR1 but Hready=1. The address latch rule applies in this cycle (back-to-back transfer accepted).
- Non-owning masters: always Hresp=00, Hrdata=0.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each DATA cycle with Hreadyout_S[k]=0. It clears on entry to DATA and when Hready=1.
  - If Hreadyout_S[k]=0 when the counter = TIMEOUT_CYCLES-1, the next state is ERR1 and timeout_err pulses high in that ERR1 cycle.
  - From ERR1 onward, Hreadyout_S[k] and Hresp_S[k] are ignored for that transfer.
  - If the slave raises Hreadyout in the same cycle the counter hits its limit, the slave completes normally (no timeout).
  - Counter width: $clog2(TIMEOUT_CYCLES+1).
- TIMEOUT_CYCLES=0: no counter logic; DATA waits indefinitely.
- Latency: zero-wait slave gives a one-cycle data phase; unmapped access costs exactly two cycles.

Test Plan:
- Reset then idle: Hresetn=0 -> Hready=1, Hresp=00, Hrdata=0. Then Htrans=00 for 5 cycles -> unchanged, timeout_err=0.
- Routed read:
  - Stimulus: Hmaster=1, NONSEQ, slave_select=4'b0100; next cycle Hrdata_S[2]=32'h1234_5678, Hreadyout_S[2]=1.
  - Required: Hrdata[1]=32'h1234_5678, Hresp[1]=00, Hrdata[0]=0, Hready=1.
- Unmapped:
  - Stimulus: NONSEQ with slave_select=0, Hmaster=0.
  - Required: cycle1 Hready=0, Hresp[0]=01, Hrdata[0]=32'hDEADBEEF; cycle2 Hready=1, Hresp[0]=01.
  - Then a NONSEQ to slave 1 presented in cycle2 is accepted with no idle gap.
- Watchdog (TIMEOUT_CYCLES=16):
  - Stimulus: slave 3 holds Hreadyout=0 for the whole data phase.
  - Required: data-phase cycles 1-16 Hready=0, Hresp=00; cycle 17 ERR1 with timeout_err=1; cycle 18 Hready=1, Hresp=01.
  - Variant: Hreadyout rises in cycle 16 -> normal OKAY completion, no pulse.
- Slave wait then ERROR passthrough: slave 0 inserts 3 wait states, then returns 01/0 then 01/1 -> outputs mirror the slave exactly; watchdog silent.
- Reset mid-error and non-one-hot select:
  - Hresetn pulsed low during ERR1 -> outputs go to reset values immediately (asynchronously).
  - After release, slave_select=4'b0011 with NONSEQ -> two-cycle ERROR.
